apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_pkg.sv | 15 +
 rtl/apb_wait_timer.sv | 30 +++
 rtl/apb_master.sv | 98 +++++++++
 tb/tb_apb_master.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the APB initiator: FSM state encoding and default sizing.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  localparam int APB_ADDR_W  = 8;
  localparam int APB_DATA_W  = 32;
  localparam int APB_TIMEOUT = 16;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts consecutive APB wait cycles; expired flags the increment that reaches TIMEOUT.
module apb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Asserted during the wait cycle whose count would become TIMEOUT.
  assign expired = inc && (cnt == LAST);

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB initiator bridging a cmd/rsp valid-ready pair onto APB with a wait timeout.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = APB_TIMEOUT
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata,
  output apb_state_e        state_dbg
);

  // Handshakes: a transfer occurs on a rising edge where valid && ready are both 1;
  // the producer holds its payload stable while valid=1 && ready=0.
  apb_state_e state, state_nxt;
  logic accept, wait_inc, expired;

  assign accept   = (state == IDLE) && cmd_valid;
  assign wait_inc = (state == ACCESS) && !pready;

  apb_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk    (pclk),
    .rst    (rst),
    .clr    (accept),
    .inc    (wait_inc),
    .expired(expired)
  );

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (pready || expired) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control strobes decode straight from state so reset drops them without a clock.
  assign cmd_ready = (state == IDLE);
  assign psel      = (state == SETUP) || (state == ACCESS);
  assign penable   = (state == ACCESS);
  assign rsp_valid = (state == RESP);
  assign state_dbg = state;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        paddr  <= cmd_addr;
        pwrite <= cmd_write;
        pwdata <= cmd_write ? cmd_wdata : '0;
      end
      // pready wins over a simultaneous expiry.
      if (state == ACCESS && pready) begin
        rsp_rdata <= pwrite ? '0 : prdata;
        rsp_err   <= 1'b0;
      end else if (expired) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: vector table of single transfers plus reset and back-to-back sequences.
module tb_apb_master;
  import apb_pkg::*;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          pclk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] paddr;
  logic          psel, penable, pwrite;
  logic [DW-1:0] pwdata;
  logic          pready;
  logic [DW-1:0] prdata;
  apb_state_e    state_dbg;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            waits;
    logic [DW-1:0] prdata;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    int            rsp_delay;
  } vec_t;

  vec_t vecs[7];

  // clock/reset block
  always #5 pclk = ~pclk;

  apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .pclk(pclk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .pready(pready), .prdata(prdata), .state_dbg(state_dbg)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  // One complete transfer; entered and left at posedge+1 with the DUT in IDLE.
  task automatic xfer(input vec_t v);
    logic [DW-1:0] exp_pwdata;
    int n_access;
    exp_pwdata = v.write ? v.wdata : '0;
    n_access   = v.exp_err ? TO : v.waits + 1;
    check("idle_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr; cmd_wdata = v.wdata;
    pready = 1'b0; prdata = v.prdata;
    step();
    cmd_valid = 1'b0; cmd_addr = ~v.addr; cmd_wdata = ~v.wdata; cmd_write = ~v.write;
    check("setup_psel", psel, 1);
    check("setup_penable", penable, 0);
    check("setup_paddr", paddr, v.addr);
    check("setup_pwrite", pwrite, v.write);
    check("setup_pwdata", pwdata, exp_pwdata);
    step();
    for (int i = 0; i < n_access; i++) begin
      check("access_psel_penable", {psel, penable}, 2'b11);
      check("access_paddr", paddr, v.addr);
      check("access_pwdata", pwdata, exp_pwdata);
      pready = !v.exp_err && (i == n_access - 1);
      step();
    end
    pready = 1'b0;
    check("resp_valid", rsp_valid, 1);
    check("resp_psel_penable", {psel, penable}, 2'b00);
    check("resp_rdata", rsp_rdata, v.exp_rdata);
    check("resp_err", rsp_err, v.exp_err);
    rsp_ready = 1'b0;
    for (int i = 0; i < v.rsp_delay; i++) begin
      cmd_valid = 1'b1; cmd_addr = 8'hA5;
      step();
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_rdata", rsp_rdata, v.exp_rdata);
      check("bp_rsp_err", rsp_err, v.exp_err);
      check("bp_cmd_ready", cmd_ready, 0);
      check("bp_paddr_hold", paddr, v.addr);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("post_rsp_valid", rsp_valid, 0);
    check("post_cmd_ready", cmd_ready, 1);
    check("post_paddr_hold", paddr, v.addr);
  endtask

  initial begin
    logic [AW-1:0] exp_addr;
    int phase;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; pready = 1'b0; prdata = '0;

    vecs[0] = '{1'b1, 8'h10, 32'hDEADBEEF, 0,  32'hFFFFFFFF, 32'h0,        1'b0, 0};
    vecs[1] = '{1'b0, 8'h24, 32'h0,        3,  32'h12345678, 32'h12345678, 1'b0, 0};
    vecs[2] = '{1'b0, 8'h33, 32'h0,        0,  32'hAAAA5555, 32'h0,        1'b1, 0};
    vecs[3] = '{1'b0, 8'h80, 32'h0,        0,  32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 5};
    vecs[4] = '{1'b0, 8'h7F, 32'h0,        TO - 1, 32'h0BADC0DE, 32'h0BADC0DE, 1'b0, 0};
    vecs[5] = '{1'b1, 8'hFF, 32'h01234567, 2,  32'h87654321, 32'h0,        1'b0, 1};
    vecs[6] = '{1'b1, 8'h01, 32'h55AA55AA, 0,  32'h11111111, 32'h0,        1'b1, 2};

    repeat (3) @(posedge pclk);
    #1;
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwrite", pwrite, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_rsp", {rsp_valid, rsp_err}, 2'b00);
    check("rst_rsp_rdata", rsp_rdata, 0);
    rst = 1'b0;
    step();
    check("rst_release_cmd_ready", cmd_ready, 1);

    for (int k = 0; k < 7; k++) xfer(vecs[k]);

    // Reset in the middle of ACCESS.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h5C; cmd_wdata = 32'h600DF00D;
    step();
    cmd_valid = 1'b0;
    step();
    check("pre_rst_access", {psel, penable}, 2'b11);
    #2 rst = 1'b1;
    #1;
    check("async_rst_psel_penable", {psel, penable}, 2'b00);
    check("async_rst_paddr", paddr, 0);
    check("async_rst_state", state_dbg, IDLE);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("discarded_no_rsp", rsp_valid, 0);
      check("discarded_idle", cmd_ready, 1);
    end
    xfer('{1'b0, 8'h42, 32'h0, 1, 32'h76543210, 32'h76543210, 1'b0, 0});

    // Back-to-back reads with cmd_valid, pready and rsp_ready all held high.
    cmd_valid = 1'b1; cmd_write = 1'b0; pready = 1'b1; rsp_ready = 1'b1; prdata = 32'h5A5AC3C3;
    exp_addr = '0;
    for (int c = 0; c < 12; c++) begin
      phase = c % 4;
      cmd_addr = AW'($urandom_range(0, 255));
      if (phase == 0) exp_addr = cmd_addr;
      check("b2b_cmd_ready", cmd_ready, phase == 0);
      check("b2b_psel", psel, phase == 1 || phase == 2);
      check("b2b_penable", penable, phase == 2);
      check("b2b_rsp_valid", rsp_valid, phase == 3);
      if (phase == 1) check("b2b_paddr", paddr, exp_addr);
      if (phase == 3) check("b2b_rsp_rdata", rsp_rdata, 32'h5A5AC3C3);
      step();
    end
    cmd_valid = 1'b0; pready = 1'b0; rsp_ready = 1'b0;
    step();
    check("b2b_end_idle", cmd_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
